tilt_to_move: RTL and testbench

Converts signed two-axis accelerometer samples into the one-hot `movement` command and the free-running `update` tick consumed by the ball stage. It applies a deadzone, selects the dominant axis and debounces direction changes over several samples. It forces the ball idle when the sensor stops producing samples. Sits between the accelerometer SPI reader and the ball/map validation logic.

---
 rtl/tilt_to_move.sv | 192 +++++++++++++++++++
 tb/tb_tilt_to_move.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilt_to_move.sv
// Accelerometer tilt to one-hot movement command with deadzone, dominant-axis select,
// debounce FSM, stale-sensor timeout and a free-running update tick. Define TILT_HYSTERESIS_EN for release hysteresis.
`timescale 1ns/1ps
module tilt_to_move #(
    parameter int SAMPLE_WIDTH     = 12,
    parameter int DEADZONE         = 64,
    parameter int HYST             = 16,
    parameter int CONFIRM_SAMPLES  = 3,
    parameter int TICK_PERIOD_CLKS = 3333333,
    parameter int STALE_CLKS       = 10000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [SAMPLE_WIDTH-1:0] accel_x,
    input  logic signed [SAMPLE_WIDTH-1:0] accel_y,
    input  logic                           accel_valid,
    output logic [3:0]                     movement,
    output logic                           update,
    output logic                           sensor_stale,
    output logic [1:0]                     state_dbg
);
    localparam int W  = SAMPLE_WIDTH;
    localparam int TW = $clog2(TICK_PERIOD_CLKS);
    localparam int SW = $clog2(STALE_CLKS + 1);
    localparam int CW = $clog2(CONFIRM_SAMPLES + 1);

    localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  MAX_POS    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  ENTER_THR  = W'(DEADZONE);
`ifdef TILT_HYSTERESIS_EN
    localparam logic [W-1:0]  RELEASE_THR = W'(DEADZONE - HYST);
`endif
    localparam logic [CW-1:0] CONFIRM_N  = CW'(CONFIRM_SAMPLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_PERIOD_CLKS - 1);
    localparam logic [TW-1:0] TICK_HALF  = TW'(TICK_PERIOD_CLKS / 2);
    localparam logic [SW-1:0] STALE_N    = SW'(STALE_CLKS);
    localparam logic [SW-1:0] STALE_LAST = SW'(STALE_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    // |v| with the most-negative code saturated so it never wraps back to negative
    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
        logic signed [W-1:0] neg;
        neg = -v;
        if (v == MOST_NEG)
            return MAX_POS;
        return v[W-1] ? $unsigned(neg) : $unsigned(v);
    endfunction

    logic [W-1:0]  mag_x_p0, mag_y_p0;
    logic          neg_x_p0, neg_y_p0;
    logic          vld_p0;
    state_t        state;
    logic [3:0]    cand, dir_q, cls;
    logic [CW-1:0] cnt, cnt_inc;
    logic [W-1:0]  thr;
    logic [TW-1:0] tcnt, tcnt_next;
    logic [SW-1:0] stale_cnt;
    logic          stale_expire;

    // Stage p0: register magnitudes and signs of the incoming sample
    always_ff @(posedge clk) begin
        if (accel_valid) begin
            mag_x_p0 <= magnitude(accel_x);
            mag_y_p0 <= magnitude(accel_y);
            neg_x_p0 <= accel_x[W-1];
            neg_y_p0 <= accel_y[W-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= accel_valid;
    end

    always_comb begin
`ifdef TILT_HYSTERESIS_EN
        thr = (state == ACTIVE) ? RELEASE_THR : ENTER_THR;
`else
        thr = ENTER_THR;
`endif
    end

    // Stage p1: classify (tie goes to X) and advance the debounce FSM
    always_comb begin
        cls = 4'b0000;
        if (mag_x_p0 >= mag_y_p0) begin
            if (mag_x_p0 >= thr)
                cls = neg_x_p0 ? 4'b0100 : 4'b1000;
        end else if (mag_y_p0 >= thr) begin
            cls = neg_y_p0 ? 4'b0001 : 4'b0010;
        end
    end

    assign cnt_inc      = cnt + 1'b1;
    assign stale_expire = !accel_valid && (stale_cnt == STALE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cand  <= 4'b0000;
            cnt   <= '0;
            dir_q <= 4'b0000;
        end else if (stale_expire) begin
            state <= IDLE;
            dir_q <= 4'b0000;
        end else if (vld_p0) begin
            case (state)
                IDLE: begin
                    if (cls != 4'b0000) begin
                        cand <= cls;
                        cnt  <= CNT_ONE;
                        if (CONFIRM_SAMPLES == 1) begin
                            state <= ACTIVE;
                            dir_q <= cls;
                        end else begin
                            state <= CANDIDATE;
                        end
                    end
                end
                CANDIDATE: begin
                    if (cls == 4'b0000) begin
                        state <= IDLE;
                    end else if (cls == cand) begin
                        if (cnt_inc >= CONFIRM_N) begin
                            state <= ACTIVE;
                            dir_q <= cand;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cand <= cls;
                        cnt  <= CNT_ONE;
                    end
                end
                ACTIVE: begin
                    if (cls == 4'b0000) begin
                        state <= IDLE;
                        dir_q <= 4'b0000;
                    end else if (cls != dir_q) begin
                        state <= CANDIDATE;
                        cand  <= cls;
                        cnt   <= CNT_ONE;
                        dir_q <= 4'b0000;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

    // Stale watchdog: a valid arriving on the expiry cycle wins over the timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stale_cnt    <= '0;
            sensor_stale <= 1'b0;
        end else if (accel_valid) begin
            stale_cnt    <= '0;
            sensor_stale <= 1'b0;
        end else if (stale_expire) begin
            stale_cnt    <= STALE_N;
            sensor_stale <= 1'b1;
        end else if (stale_cnt != STALE_N) begin
            stale_cnt <= stale_cnt + 1'b1;
        end
    end

    // Tick generator; movement only changes in the low phase so it is stable at every update rise
    assign tcnt_next = (tcnt == TICK_LAST) ? '0 : tcnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt     <= '0;
            update   <= 1'b0;
            movement <= 4'b0000;
        end else begin
            tcnt   <= tcnt_next;
            update <= (tcnt_next >= TICK_HALF);
            if (tcnt == '0)
                movement <= (sensor_stale || stale_expire) ? 4'b0000 : dir_q;
        end
    end
endmodule

// File: tb/tb_tilt_to_move.sv
// Scoreboard bench for tilt_to_move: a spec-level model predicts the FSM state per sample
// and the movement seen at update rising edges; a monitor process compares.
`timescale 1ns/1ps
module tb_tilt_to_move;
    localparam int SW_ = 12;
    localparam int DZ  = 64;
    localparam int HY  = 16;
    localparam int TP  = 8;
`ifdef TILT_HYSTERESIS_EN
    localparam int REL_THR = DZ - HY;
`else
    localparam int REL_THR = DZ;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic signed [SW_-1:0] accel_x, accel_y;
    logic                  accel_valid;
    logic [3:0]            movement;
    logic                  update, sensor_stale;
    logic [1:0]            state_dbg;

    always #5 clk = ~clk;

    tilt_to_move #(
        .SAMPLE_WIDTH(SW_), .DEADZONE(DZ), .HYST(HY), .CONFIRM_SAMPLES(3),
        .TICK_PERIOD_CLKS(TP), .STALE_CLKS(100)
    ) dut (
        .clk(clk), .reset(reset), .accel_x(accel_x), .accel_y(accel_y),
        .accel_valid(accel_valid), .movement(movement), .update(update),
        .sensor_stale(sensor_stale), .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int         q_state[$];
    logic [3:0] q_move[$];

    // behavioural model state: 0 idle, 1 candidate, 2 active
    int         m_state = 0;
    int         m_cnt   = 0;
    logic [3:0] m_cand  = 4'b0000;
    logic [3:0] m_dir   = 4'b0000;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int mag_of(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 2047) ? 2047 : a;
    endfunction

    function automatic int clamp12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic model_step(input int x, input int y);
        int mx, my, thr;
        logic [3:0] c;
        mx  = mag_of(x);
        my  = mag_of(y);
        thr = (m_state == 2) ? REL_THR : DZ;
        c   = 4'b0000;
        if (mx >= my) begin
            if (mx >= thr) c = (x >= 0) ? 4'b1000 : 4'b0100;
        end else if (my >= thr) begin
            c = (y >= 0) ? 4'b0010 : 4'b0001;
        end
        if (m_state == 0) begin
            if (c != 0) begin m_state = 1; m_cand = c; m_cnt = 1; end
        end else if (m_state == 1) begin
            if (c == 0) m_state = 0;
            else if (c == m_cand) begin
                m_cnt++;
                if (m_cnt >= 3) begin m_state = 2; m_dir = m_cand; end
            end else begin m_cand = c; m_cnt = 1; end
        end else begin
            if (c == 0) begin m_state = 0; m_dir = 0; end
            else if (c != m_dir) begin m_state = 1; m_cand = c; m_cnt = 1; m_dir = 0; end
        end
    endtask

    task automatic send(input int x, input int y);
        @(negedge clk);
        accel_x     = SW_'(x);
        accel_y     = SW_'(y);
        accel_valid = 1'b1;
        model_step(x, y);
        q_state.push_back(m_state);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            accel_valid = 1'b0;
        end
    endtask

    task automatic expect_move();
        int k;
        idle(12);
        q_move.push_back(m_dir);
        k = 0;
        while (q_move.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("movement_popped", q_move.size(), 0);
        q_move.delete();
    endtask

    // monitor: state two edges after each sample, movement at each update rise
    logic v1 = 1'b0, v2 = 1'b0, prev_upd = 1'b0;
    always @(posedge clk) begin
        v1 <= accel_valid;
        v2 <= v1;
    end

    always @(negedge clk) begin
        int e;
        if (reset === 1'b1 && v2) begin
            if (q_state.size() > 0) begin
                e = q_state.pop_front();
                check("state_dbg", int'(state_dbg), e);
            end else begin
                check("state_queue_nonempty", q_state.size(), 1);
            end
        end
        if (reset === 1'b1 && update && !prev_upd && q_move.size() > 0) begin
            e = int'(q_move.pop_front());
            check("movement", int'(movement), e);
        end
        prev_upd = update;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; accel_valid = 1'b0; accel_x = '0; accel_y = '0;
        repeat (3) @(negedge clk);
        check("rst_movement", int'(movement), 0);
        check("rst_update", int'(update), 0);
        check("rst_stale", int'(sensor_stale), 0);
        check("rst_state", int'(state_dbg), 0);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("update_tick", int'(update), ((k % TP) >= TP / 2) ? 1 : 0);
        end

        // confirmation and fall back to idle
        repeat (3) send(100, 10);
        expect_move();
        send(0, 0);
        expect_move();
        repeat (2) send(100, 10);
        send(0, 10);
        expect_move();

        // dominance, tie and most-negative sample
        repeat (3) send(-80, 90);
        expect_move();
        repeat (3) send(-90, 90);
        expect_move();
        send(0, 0);
        repeat (3) send(-2048, 0);
        expect_move();

        // hysteresis boundary
        send(0, 0);
        repeat (3) send(100, 0);
        expect_move();
        send(50, 0);
        expect_move();
        send(48, 0);
        send(47, 0);
        expect_move();

        // stale timeout and valid on the expiry cycle
        send(0, 0);
        repeat (3) send(0, -120);
        expect_move();
        send(0, -120);
        idle(1);
        repeat (99) @(negedge clk);
        check("stale_before_expiry", int'(sensor_stale), 0);
        @(negedge clk);
        m_state = 0; m_dir = 4'b0000;
        check("stale_at_expiry", int'(sensor_stale), 1);
        check("state_after_stale", int'(state_dbg), m_state);
        expect_move();
        send(0, -120);
        check("stale_cleared", int'(sensor_stale), 1);
        idle(1);
        check("stale_cleared_after_valid", int'(sensor_stale), 0);
        repeat (98) @(negedge clk);
        send(0, -120);
        idle(1);
        check("stale_valid_wins", int'(sensor_stale), 0);
        send(0, -120);
        expect_move();

        // randomized rounds
        for (int r = 0; r < 16; r++) begin
            int bx, by, reps;
            case ($urandom_range(0, 2))
                0: begin bx = int'($urandom_range(0, 4095)) - 2048; by = int'($urandom_range(0, 4095)) - 2048; end
                1: begin bx = int'($urandom_range(0, 140)) - 70; by = int'($urandom_range(0, 140)) - 70; end
                default: begin
                    bx = int'($urandom_range(0, 600)) - 300;
                    by = int'($urandom_range(0, 60)) - 30;
                    if ($urandom_range(0, 1) == 1) begin int t; t = bx; bx = by; by = t; end
                end
            endcase
            reps = int'($urandom_range(1, 4));
            for (int i = 0; i < reps; i++) begin
                send(clamp12(bx + int'($urandom_range(0, 6)) - 3),
                     clamp12(by + int'($urandom_range(0, 6)) - 3));
                idle(int'($urandom_range(0, 2)));
            end
            expect_move();
        end

        // direction change through candidate
        send(0, 0);
        repeat (3) send(100, 0);
        expect_move();
        send(0, -120);
        expect_move();
        repeat (2) send(0, -120);
        expect_move();

        // asynchronous reset mid-tick
        begin
            int k;
            k = 0;
            while (update !== 1'b1 && k < 20) begin @(negedge clk); k++; end
            check("update_high_before_reset", int'(update), 1);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_movement", int'(movement), 0);
        check("async_update", int'(update), 0);
        check("async_stale", int'(sensor_stale), 0);
        check("async_state", int'(state_dbg), 0);
        #20;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
